// File: rtl/pixel_raster_core.sv
// ----------------------------------------------------------------------------
// pixel_raster_core
//
// Two-stage rectangle rasterizer. Up to NUM_POLY rectangle slots are programmed
// through a shadow bank and committed to an active bank at frame start
// (cmp_en=1 at row 0, col 0). Each accepted pixel is tested against every
// enabled active slot. The lowest-index hit wins. A hit slot may apply
// checkerboard shading on odd-parity pixels. Where no slot hits, the pixel
// takes the background colour.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   cmp_en            pixel is in the active area and is rasterized
//   pixel_row/col     current pixel coordinates (9 / 10 bits)
//   background_color  colour used where no enabled slot hits
//   en_polygon        per-slot enable, sampled with the pixel
//   cfg_we/cfg_idx    shadow-slot write strobe and index (out-of-range ignored)
//   cfg_x0/x1/y0/y1   inclusive rectangle bounds
//   cfg_color/shade   slot colour and checkerboard-shading flag
//   pixel_out/valid   registered result, two clocks after the pixel input
// ----------------------------------------------------------------------------
module pixel_raster_core #(
    parameter int NUM_POLY = 4,
    parameter int COLOR_W  = 6,
    localparam int IDX_W   = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmp_en,
    input  logic [8:0]          pixel_row,
    input  logic [9:0]          pixel_col,
    input  logic [COLOR_W-1:0]  background_color,
    input  logic [NUM_POLY-1:0] en_polygon,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [9:0]          cfg_x0,
    input  logic [9:0]          cfg_x1,
    input  logic [8:0]          cfg_y0,
    input  logic [8:0]          cfg_y1,
    input  logic [COLOR_W-1:0]  cfg_color,
    input  logic                cfg_shade,
    output logic [COLOR_W-1:0]  pixel_out,
    output logic                pixel_valid
);

    typedef struct packed {
        logic [9:0]         x0;
        logic [9:0]         x1;
        logic [8:0]         y0;
        logic [8:0]         y1;
        logic [COLOR_W-1:0] color;
        logic               shade;
    } slot_t;

    // x0 > x1 makes the slot empty, so a reset slot can never hit.
    localparam slot_t SLOT_RESET = '{
        x0: 10'd1, x1: 10'd0, y0: 9'd0, y1: 9'd0, color: '0, shade: 1'b0
    };

    // Shading keeps the MSB of each 2-bit channel: pattern 10..10.
    function automatic logic [COLOR_W-1:0] shade_mask_f();
        logic [COLOR_W-1:0] m;
        m = '0;
        for (int k = 0; k < COLOR_W; k++) begin
            m[k] = (k % 2) == 1;
        end
        return m;
    endfunction

    localparam logic [COLOR_W-1:0] SHADE_MASK = shade_mask_f();

    // ------------------------------------------------------------------
    // Slot banks
    // ------------------------------------------------------------------
    slot_t shadow_q [NUM_POLY];
    slot_t active_q [NUM_POLY];

    logic  frame_start;
    logic  cfg_wr;
    slot_t cfg_slot;

    assign frame_start = cmp_en && (pixel_row == 9'd0) && (pixel_col == 10'd0);
    assign cfg_wr      = cfg_we && (32'(cfg_idx) < NUM_POLY);
    assign cfg_slot    = '{x0: cfg_x0, x1: cfg_x1, y0: cfg_y0, y1: cfg_y1,
                           color: cfg_color, shade: cfg_shade};

    // NOTE: both banks are reset (unlike the pipeline data below) because a
    // slot must read as never-hit straight out of reset. Non-blocking
    // assignments make the frame-start copy take the pre-write shadow
    // contents when a write lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_POLY; i++) begin
                shadow_q[i] <= SLOT_RESET;
                active_q[i] <= SLOT_RESET;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_POLY; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (cfg_wr) begin
                shadow_q[cfg_idx] <= cfg_slot;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: hit test against the active bank as it stands this cycle
    // ------------------------------------------------------------------
    logic [NUM_POLY-1:0] hit_d;

    // NOTE: every always_comb output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NUM_POLY; i++) begin
            // Inverted bounds fail one of the two range tests automatically.
            hit_d[i] = en_polygon[i]
                    && (pixel_col >= active_q[i].x0) && (pixel_col <= active_q[i].x1)
                    && (pixel_row >= active_q[i].y0) && (pixel_row <= active_q[i].y1);
        end
    end

    logic                valid1_q;
    logic [NUM_POLY-1:0] hit_q;
    logic                parity_q;
    logic [COLOR_W-1:0]  bg_q;
    logic [COLOR_W-1:0]  color_q [NUM_POLY];
    logic [NUM_POLY-1:0] shade_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= cmp_en;
        end
    end

    // Stage-1 data is only meaningful alongside valid1_q, so it carries no
    // reset. Slot colours are captured here so that a frame-start commit
    // cannot change the colour of a pixel already past its hit test.
    always_ff @(posedge clk) begin
        hit_q    <= hit_d;
        parity_q <= pixel_row[0] ^ pixel_col[0];
        bg_q     <= background_color;
        for (int i = 0; i < NUM_POLY; i++) begin
            color_q[i] <= active_q[i].color;
            shade_q[i] <= active_q[i].shade;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority select, shading, output register
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] sel_color;
    logic               found;

    always_comb begin
        sel_color = bg_q;
        found     = 1'b0;
        for (int i = 0; i < NUM_POLY; i++) begin
            if (!found && hit_q[i]) begin
                found     = 1'b1;
                sel_color = (shade_q[i] && parity_q) ? (color_q[i] & SHADE_MASK)
                                                     : color_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_out   <= valid1_q ? sel_color : '0;
            pixel_valid <= valid1_q;
        end
    end

endmodule

// File: tb/tb_pixel_raster_core.sv
// ----------------------------------------------------------------------------
// tb_pixel_raster_core
//
// Self-checking bench for pixel_raster_core. A behavioural model tracks the
// shadow and active banks as plain integer records and computes each pixel
// from the rectangle rules. Every cycle compares pixel_out/pixel_valid with
// the model result from two clocks earlier. A table of directed vectors
// carries its own expected colours. Hand-written sequences cover reset.
// ----------------------------------------------------------------------------
module tb_pixel_raster_core;

    localparam int N  = 3;   // 3 slots: index 3 is out of range
    localparam int CW = 6;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmp_en;
    logic [8:0]    pixel_row;
    logic [9:0]    pixel_col;
    logic [CW-1:0] background_color;
    logic [N-1:0]  en_polygon;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [9:0]    cfg_x0, cfg_x1;
    logic [8:0]    cfg_y0, cfg_y1;
    logic [CW-1:0] cfg_color;
    logic          cfg_shade;
    logic [CW-1:0] pixel_out;
    logic          pixel_valid;

    pixel_raster_core #(.NUM_POLY(N), .COLOR_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmp_en           (cmp_en),
        .pixel_row        (pixel_row),
        .pixel_col        (pixel_col),
        .background_color (background_color),
        .en_polygon       (en_polygon),
        .cfg_we           (cfg_we),
        .cfg_idx          (cfg_idx),
        .cfg_x0           (cfg_x0),
        .cfg_x1           (cfg_x1),
        .cfg_y0           (cfg_y0),
        .cfg_y1           (cfg_y1),
        .cfg_color        (cfg_color),
        .cfg_shade        (cfg_shade),
        .pixel_out        (pixel_out),
        .pixel_valid      (pixel_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        int x0, x1, y0, y1, color, shade;
    } mslot_t;

    mslot_t m_shadow [N];
    mslot_t m_active [N];
    int     p1_col, p2_col;
    bit     p1_v, p2_v;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = '{1, 0, 0, 0, 0, 0};
            m_active[i] = '{1, 0, 0, 0, 0, 0};
        end
        p1_col = 0; p2_col = 0; p1_v = 0; p2_v = 0;
    endtask

    // Each 2-bit channel keeps only its MSB: values 2,3 -> 2; 0,1 -> 0.
    function automatic int shaded(input int c);
        int res = 0;
        for (int ch = 0; ch < CW / 2; ch++) begin
            if (((c >> (2 * ch)) & 3) >= 2) res += 2 << (2 * ch);
        end
        return res;
    endfunction

    function automatic int model_pixel(input int r, input int c, input int en, input int bg);
        for (int i = 0; i < N; i++) begin
            if (((en >> i) & 1) == 1 &&
                c >= m_active[i].x0 && c <= m_active[i].x1 &&
                r >= m_active[i].y0 && r <= m_active[i].y1) begin
                if (m_active[i].shade == 1 && ((r + c) % 2) == 1)
                    return shaded(m_active[i].color);
                return m_active[i].color;
            end
        end
        return bg;
    endfunction

    // One clock: predict from the current inputs, advance, update the model,
    // then compare the result from two clocks back.
    task automatic tick();
        int  exp_c;
        bit  exp_v, fs, wr;
        int  idx;
        exp_v = cmp_en;
        exp_c = cmp_en ? model_pixel(int'(pixel_row), int'(pixel_col),
                                     int'(en_polygon), int'(background_color)) : 0;
        fs  = cmp_en && pixel_row == 0 && pixel_col == 0;
        idx = int'(cfg_idx);
        wr  = cfg_we && idx < N;
        @(posedge clk);
        if (fs) for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
        if (wr) m_shadow[idx] = '{int'(cfg_x0), int'(cfg_x1), int'(cfg_y0), int'(cfg_y1),
                                  int'(cfg_color), int'(cfg_shade)};
        p2_col = p1_col; p2_v = p1_v;
        p1_col = exp_c;  p1_v = exp_v;
        #1;
        check("pipe_valid", pixel_valid, p2_v);
        check("pipe_pixel", pixel_out, p2_col);
    endtask

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        bit we;
        int idx, x0, x1, y0, y1, color, shade;
        bit ce;
        int row, col, en, bg;
        int exp;
        bit chk;
    } vec_t;

    function automatic vec_t cfgv(input int idx, input int x0, input int x1,
                                  input int y0, input int y1, input int color, input int shade);
        vec_t v = '{1, idx, x0, x1, y0, y1, color, shade, 0, 0, 0, 0, 'h15, 0, 0};
        return v;
    endfunction

    function automatic vec_t pixv(input int row, input int col, input int en, input int exp);
        vec_t v = '{0, 0, 0, 0, 0, 0, 0, 0, 1, row, col, en, 'h15, exp, 1};
        return v;
    endfunction

    function automatic vec_t with_pix(input vec_t v, input int row, input int col,
                                      input int en, input int exp);
        vec_t r = v;
        r.ce = 1; r.row = row; r.col = col; r.en = en; r.exp = exp; r.chk = 1;
        return r;
    endfunction

    task automatic idle_inputs();
        cmp_en = 0; cfg_we = 0; pixel_row = '0; pixel_col = '0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        cfg_we    = v.we;
        cfg_idx   = v.idx[IW-1:0];
        cfg_x0    = v.x0[9:0];
        cfg_x1    = v.x1[9:0];
        cfg_y0    = v.y0[8:0];
        cfg_y1    = v.y1[8:0];
        cfg_color = v.color[CW-1:0];
        cfg_shade = v.shade[0];
        cmp_en    = v.ce;
        pixel_row = v.row[8:0];
        pixel_col = v.col[9:0];
        en_polygon       = v.en[N-1:0];
        background_color = v.bg[CW-1:0];
        tick();
        idle_inputs();
        tick();
        if (v.chk) check(name, pixel_out, v.exp);
    endtask

    vec_t vt[$];

    initial begin
        // Table: reset view, commit, frame-start pixel, priority, bounds,
        // shading, write coincident with frame start, ignored index, empty slot.
        vt.push_back(pixv(5, 5, 7, 'h15));
        vt.push_back(cfgv(0, 10, 20, 10, 20, 'h30, 0));
        vt.push_back(pixv(15, 15, 7, 'h15));
        vt.push_back(cfgv(2, 0, 5, 0, 5, 'h03, 0));
        vt.push_back(pixv(0, 0, 7, 'h15));
        vt.push_back(pixv(15, 15, 7, 'h30));
        vt.push_back(pixv(0, 0, 7, 'h03));
        vt.push_back(cfgv(1, 5, 14, 5, 14, 'h0C, 0));
        vt.push_back(pixv(0, 0, 7, 'h03));
        vt.push_back(pixv(12, 12, 7, 'h30));
        vt.push_back(pixv(12, 12, 6, 'h0C));
        vt.push_back(pixv(15, 21, 7, 'h15));
        vt.push_back(pixv(3, 3, 3, 'h15));
        vt.push_back(cfgv(0, 10, 20, 10, 20, 'h3F, 1));
        vt.push_back(pixv(0, 0, 7, 'h03));
        vt.push_back(pixv(12, 12, 7, 'h3F));
        vt.push_back(pixv(12, 13, 7, 'h2A));
        vt.push_back(pixv(13, 20, 7, 'h2A));
        vt.push_back(pixv(20, 20, 7, 'h3F));
        vt.push_back(with_pix(cfgv(0, 10, 20, 10, 20, 'h11, 0), 0, 0, 7, 'h03));
        vt.push_back(pixv(15, 16, 7, 'h2A));
        vt.push_back(pixv(0, 0, 7, 'h03));
        vt.push_back(pixv(15, 16, 7, 'h11));
        vt.push_back(cfgv(3, 0, 31, 0, 31, 'h3F, 0));
        vt.push_back(pixv(0, 0, 7, 'h03));
        vt.push_back(pixv(25, 25, 7, 'h15));
        vt.push_back(cfgv(1, 14, 5, 5, 14, 'h0C, 0));
        vt.push_back(pixv(0, 0, 7, 'h03));
        vt.push_back(pixv(8, 8, 7, 'h15));

        // Power-on reset
        rst_n = 0;
        idle_inputs();
        en_polygon = '0; background_color = '0; cfg_idx = '0;
        cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0;
        cfg_color = '0; cfg_shade = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", pixel_valid, 0);
        check("rst_pixel", pixel_out, 0);
        #2 rst_n = 1;

        for (int i = 0; i < vt.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vt[i]);
        end

        // Mid-stream reset with pixels in flight
        run_vec("pre_rst", pixv(15, 16, 7, 'h11));
        cmp_en = 1; pixel_row = 9'd15; pixel_col = 10'd15; en_polygon = '1;
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        check("mid_rst_valid", pixel_valid, 0);
        check("mid_rst_pixel", pixel_out, 0);
        model_reset();
        // A write and a frame start during reset are both discarded.
        cfg_we = 1; cfg_idx = '0; cfg_x0 = '0; cfg_x1 = 10'd31; cfg_y0 = '0; cfg_y1 = 9'd31;
        cfg_color = 6'h3F; cfg_shade = 0;
        cmp_en = 1; pixel_row = '0; pixel_col = '0;
        @(posedge clk);
        #1;
        check("in_rst_valid", pixel_valid, 0);
        check("in_rst_pixel", pixel_out, 0);
        #2 rst_n = 1;
        idle_inputs();
        run_vec("post_rst_fs0", pixv(0, 0, 7, 'h15));
        run_vec("post_rst_p0",  pixv(15, 15, 7, 'h15));
        run_vec("post_rst_fs1", pixv(0, 0, 7, 'h15));
        run_vec("post_rst_p1",  pixv(15, 15, 7, 'h15));
        run_vec("post_rst_p2",  pixv(12, 12, 7, 'h15));

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_idx   = IW'($urandom_range(0, 3));
            cfg_x0    = 10'($urandom_range(0, 31));
            cfg_x1    = 10'($urandom_range(0, 31));
            cfg_y0    = 9'($urandom_range(0, 31));
            cfg_y1    = 9'($urandom_range(0, 31));
            cfg_color = CW'($urandom);
            cfg_shade = $urandom_range(0, 1) == 1;
            cmp_en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                pixel_row = '0; pixel_col = '0;
            end else begin
                pixel_row = 9'($urandom_range(0, 31));
                pixel_col = 10'($urandom_range(0, 31));
            end
            en_polygon       = N'($urandom);
            background_color = CW'($urandom);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_raster_core.md
PIXEL_RASTER_CORE -- requirements
Module: pixel_raster_core

Interface
REQ-001 SHALL have parameter NUM_POLY, default 4, meaning number of rectangle slots (1..16).
REQ-002 SHALL have parameter COLOR_W, default 6, meaning even colour width, packed as 2-bit R,G,B channels, MSB first.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port cmp_en  input  1  meaning the current pixel is in the active area and is rasterized.
REQ-006 SHALL have port pixel_row  input  9  meaning current pixel row.
REQ-007 SHALL have port pixel_col  input  10  meaning current pixel column.
REQ-008 SHALL have port background_color  input  COLOR_W  meaning colour used where no enabled slot hits.
REQ-009 SHALL have port en_polygon  input  NUM_POLY  meaning per-slot enable, sampled in stage 1.
REQ-010 SHALL have port cfg_we  input  1  meaning slot write strobe.
REQ-011 SHALL have port cfg_idx  input  max(1,clog2(NUM_POLY))  meaning slot index written.
REQ-012 SHALL have ports cfg_x0/cfg_x1  input  10, and cfg_y0/cfg_y1  input  9, meaning inclusive rectangle bounds.
REQ-013 SHALL have port cfg_color  input  COLOR_W  meaning slot colour.
REQ-014 SHALL have port cfg_shade  input  1  meaning slot uses checkerboard shading.
REQ-015 SHALL have port pixel_out  output  COLOR_W  meaning registered pixel colour.
REQ-016 SHALL have port pixel_valid  output  1  meaning pixel_out corresponds to a cmp_en=1 input two cycles earlier.

Function
REQ-017 SHALL hold two slot banks, shadow and active; cfg_we with cfg_idx<NUM_POLY writes the shadow slot; cfg_idx>=NUM_POLY is ignored.
REQ-018 SHALL copy the entire shadow bank to the active bank on the cycle where cmp_en=1, pixel_row=0, pixel_col=0 (frame start).
REQ-019 SHALL, on simultaneous cfg_we and frame start, copy pre-write shadow contents; the write lands in shadow only, visible from the next frame.
REQ-020 SHALL use the active bank for rasterization of the frame-start pixel itself (the copy is used from the following pixel onward).
REQ-021 SHALL in stage 1 register hit[i] = en_polygon[i] & x0<=col<=x1 & y0<=row<=y1 using active slot i, plus row[0]^col[0], background_color and cmp_en.
REQ-022 SHALL treat a slot with x1<x0 or y1<y0 as never hitting.
REQ-023 SHALL in stage 2 select the lowest-index hit slot; no hit selects background_color.
REQ-024 SHALL for a selected slot with shade=1 and registered parity=1 output the colour ANDed with the alternating mask 10..10 (keep each channel MSB); otherwise output the colour unchanged; background is never shaded.
REQ-025 SHALL, when stage-2 valid is 0, drive pixel_out to all zeros (black).
REQ-026 SHALL have fixed latency of 2 clocks from inputs to pixel_out/pixel_valid, with one new pixel accepted every cycle and no stalls.

Reset
REQ-027 SHALL on rst_n=0 immediately clear pixel_out to 0, pixel_valid to 0, all pipeline valids to 0.
REQ-028 SHALL on reset clear all shadow and active slots to x0=1, x1=0, y0=0, y1=0, colour 0, shade 0 (never hit).
REQ-029 SHALL discard a cfg_we or frame start coincident with rst_n=0; operation resumes on the first rising edge after deassertion.

Verification
REQ-030 SHALL verify reset: after reset, cmp_en=1 at row 5 col 5, background 6'h15 -> pixel_out=6'h15, pixel_valid=1 two cycles later.
REQ-031 SHALL verify commit: write slot 0 (10,10)-(20,20) colour 6'h30, no frame start -> pixel (15,15) shows background; after frame start -> 6'h30.
REQ-032 SHALL verify priority and bounds: slots 0 and 1 overlap at (12,12), colours 6'h30/6'h0C -> 6'h30; disabling en_polygon[0] -> 6'h0C; pixel (21,15) -> background.
REQ-033 SHALL verify shading: slot shade=1 colour 6'h3F -> (row+col) even gives 6'h3F, odd gives 6'h2A.
REQ-034 SHALL verify simultaneous cfg_we and frame start: new colour absent in that frame, present after the next frame start.
REQ-035 SHALL verify mid-stream reset: assert rst_n=0 with valid pixels in flight -> pixel_valid=0 and pixel_out=0 immediately, and all slots revert to never-hit.
